// File: rtl/queue_reg.sv
// queue_reg: synchronous FIFO holding feature-map pixels between the upstream
// stream and the padding controller. Depth may be any integer >= 2; pointers
// wrap explicitly at depth-1, so no power-of-two depth is assumed.
// Read data is registered: dout updates one clock after an accepted read and
// then holds until the next accepted read.
// Optional build macro QUEUE_REG_STATUS_EN adds empty/full/level outputs,
// all decoded combinationally from the registered occupancy count.
module queue_reg #(
   parameter int width = 24,
   parameter int depth = 94
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         input_vld,
   input  logic                         read_flag,
   input  logic [width-1:0]             din,
   output logic [width-1:0]             dout
`ifdef QUEUE_REG_STATUS_EN
   ,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(depth+1)-1:0]   level
`endif
);

   localparam int PTR_W = (depth > 2) ? $clog2(depth) : 1;
   localparam int CNT_W = $clog2(depth + 1);

   logic [width-1:0] mem [depth];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic is_empty;
   logic is_full;
   logic wr_en;
   logic rd_en;

   // Pointer increment with explicit wrap at the last entry.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_empty = (count == '0);
   assign is_full  = (count == CNT_W'(depth));

   // A full FIFO can still take a write when a read frees the head slot in
   // the same cycle; a read on an empty FIFO is ignored (no fall-through).
   assign rd_en = read_flag & ~is_empty;
   assign wr_en = input_vld & (~is_full | rd_en);

`ifdef QUEUE_REG_STATUS_EN
   assign empty = is_empty;
   assign full  = is_full;
   assign level = count;
`endif

   // Storage array: written on accepted writes, never cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and registered read data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_en) begin
            rd_ptr <= ptr_inc(rd_ptr);
            dout   <= mem[rd_ptr];
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_queue_reg.sv
// tb_queue_reg: directed bench for queue_reg at the default 24 x 94 geometry.
// A reference queue models FIFO contents; values read out are pushed to a
// scoreboard queue when the read is driven and popped when dout is sampled.
module tb_queue_reg;

   localparam int W     = 24;
   localparam int DEPTH = 94;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_n;
   logic          input_vld;
   logic          read_flag;
   logic [W-1:0]  din;
   logic [W-1:0]  dout;
`ifdef QUEUE_REG_STATUS_EN
   logic          empty;
   logic          full;
   logic [CW-1:0] level;
`endif

   queue_reg #(.width(W), .depth(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .input_vld (input_vld),
      .read_flag (read_flag),
      .din       (din),
      .dout      (dout)
`ifdef QUEUE_REG_STATUS_EN
      ,
      .empty     (empty),
      .full      (full),
      .level     (level)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic [W-1:0] model_q [$];
   logic [W-1:0] exp_q   [$];
   logic [W-1:0] model_dout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock of stimulus; the model decides acceptance from its own state.
   task automatic step(input logic vld, input logic [W-1:0] d, input logic rd);
      bit rd_acc;
      bit wr_acc;
      rd_acc = rd && (model_q.size() != 0);
      wr_acc = vld && ((model_q.size() < DEPTH) || rd_acc);
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(d);
      input_vld = vld;
      din       = d;
      read_flag = rd;
      @(posedge clk);
      #1;
      input_vld = 1'b0;
      read_flag = 1'b0;
      din       = '0;
      if (rd_acc) model_dout = exp_q.pop_front();
      check("dout", {8'h0, dout}, {8'h0, model_dout});
`ifdef QUEUE_REG_STATUS_EN
      check("level", 32'(level), 32'(model_q.size()));
      check("empty", 32'(empty), 32'(model_q.size() == 0));
      check("full",  32'(full),  32'(model_q.size() == DEPTH));
`endif
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      input_vld = 1'b0;
      read_flag = 1'b0;
      din       = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_q.delete();
      exp_q.delete();
      model_dout = '0;
      check("reset_dout", {8'h0, dout}, 32'h0);
   endtask

   initial begin
      rst_n      = 1'b1;
      input_vld  = 1'b0;
      read_flag  = 1'b0;
      din        = '0;
      model_dout = '0;

      // Reset, idle, read on empty.
      do_reset();
      step(1'b0, '0, 1'b0);
      check("idle_dout", {8'h0, dout}, 32'h0);
      step(1'b0, '0, 1'b1);
      check("empty_read_dout", {8'h0, dout}, 32'h0);

      // Three writes, three reads.
      for (int i = 1; i <= 3; i++) step(1'b1, W'(i), 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, '0, 1'b1);
         check("basic_read", {8'h0, dout}, 32'(i));
      end

      // Wrap-around: 94 in, 50 out, 50 in, 94 out.
      for (int i = 0; i < 94; i++) step(1'b1, W'(i), 1'b0);
      for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b1);
      check("wrap_mid", {8'h0, dout}, 32'd49);
      for (int i = 94; i < 144; i++) step(1'b1, W'(i), 1'b0);
      for (int i = 0; i < 94; i++) begin
         step(1'b0, '0, 1'b1);
         check("wrap_read", {8'h0, dout}, 32'(50 + i));
      end
      step(1'b0, '0, 1'b1);
      check("wrap_drained_hold", {8'h0, dout}, 32'd143);

      // Full: 95th write dropped.
      do_reset();
      for (int i = 0; i < 95; i++) step(1'b1, W'(i), 1'b0);
      for (int i = 0; i < 94; i++) begin
         step(1'b0, '0, 1'b1);
         check("full_read", {8'h0, dout}, 32'(i));
      end
      step(1'b0, '0, 1'b1);
      check("full_extra_read_hold", {8'h0, dout}, 32'd93);

      // Simultaneous read and write while full.
      for (int i = 0; i < 94; i++) step(1'b1, W'(i), 1'b0);
      step(1'b1, W'(24'hAAAAAA), 1'b1);
      check("simul_full_dout", {8'h0, dout}, 32'h0);
      for (int i = 1; i < 94; i++) step(1'b0, '0, 1'b1);
      check("simul_full_pre_last", {8'h0, dout}, 32'd93);
      step(1'b0, '0, 1'b1);
      check("simul_full_last", {8'h0, dout}, 32'hAAAAAA);

      // Simultaneous read and write while empty: no fall-through.
      step(1'b1, W'(24'h55), 1'b1);
      check("simul_empty_hold", {8'h0, dout}, 32'hAAAAAA);
      step(1'b0, '0, 1'b1);
      check("simul_empty_next", {8'h0, dout}, 32'h55);

      // Reset mid-operation discards queued data.
      for (int i = 0; i < 5; i++) step(1'b1, W'(24'h100 + i), 1'b0);
      do_reset();
      step(1'b0, '0, 1'b1);
      check("post_reset_read", {8'h0, dout}, 32'h0);
      step(1'b1, W'(24'h77), 1'b0);
      step(1'b0, '0, 1'b1);
      check("post_reset_fresh", {8'h0, dout}, 32'h77);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
